stream_arb_mux: RTL

STREAM_ARB_MUX -- requirements
Module: stream_arb_mux

---
 rtl/stream_arb_mux_pkg.sv | 24 ++
 rtl/stream_arb_mux_if.sv | 28 ++
 rtl/stream_arb_mux_arb.sv | 30 +++
 rtl/stream_arb_mux.sv | 114 +++++++++++
 4 files changed

// File: rtl/stream_arb_mux_pkg.sv
// Shared constants, FSM state type and width helpers for the stream arbiter/mux.
package stream_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

   // Channel index width; a single channel still needs one bit.
   function automatic int ch_wd(input int n);
      return (clog2(n) > 1) ? clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_arb_mux_if.sv
// N-input packet stream bundle plus the single muxed output stream.
interface stream_arb_mux_if #(
   parameter int DATA_WD = 4,
   parameter int N_CH    = 4
);
   localparam int CH_WD = stream_pkg::ch_wd(N_CH);

   logic [N_CH*DATA_WD-1:0] s_data;
   logic [N_CH-1:0]         s_valid;
   logic [N_CH-1:0]         s_last;
   logic [N_CH-1:0]         s_ready;
   logic [DATA_WD-1:0]      m_data;
   logic                    m_valid;
   logic                    m_last;
   logic [CH_WD-1:0]        m_src;
   logic                    m_ready;
   logic                    busy;

   modport slave (
      input  s_data, s_valid, s_last, m_ready,
      output s_ready, m_data, m_valid, m_last, m_src, busy
   );

   modport master (
      output s_data, s_valid, s_last, m_ready,
      input  s_ready, m_data, m_valid, m_last, m_src, busy
   );
endinterface

// File: rtl/stream_arb_mux_arb.sv
// Combinational arbiter: round-robin from ptr (mode=0) or lowest index wins (mode=1).
module rr_arbiter #(
   parameter int N_CH  = 4,
   parameter int CH_WD = 2
) (
   input  logic [N_CH-1:0]  req,
   input  logic [CH_WD-1:0] ptr,
   input  logic             mode,
   output logic [CH_WD-1:0] grant,
   output logic             grant_valid
);

   // Scan from the farthest candidate down so the nearest one overwrites last.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      for (int k = N_CH - 1; k >= 0; k--) begin
         if (mode) begin
            if (req[k]) begin
               grant       = CH_WD'(k);
               grant_valid = 1'b1;
            end
         end else if (req[(int'(ptr) + k) % N_CH]) begin
            grant       = CH_WD'((int'(ptr) + k) % N_CH);
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_arb_mux.sv
// Packet-locked N:1 stream arbiter feeding a single output register slice.
module stream_arb_mux
   import stream_pkg::*;
#(
   parameter int DATA_WD  = 4,
   parameter int N_CH     = 4,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic            clk,
   input  logic            rstn,
   stream_arb_mux_if.slave bus
);

   localparam int               CH_WD   = ch_wd(N_CH);
   localparam logic [CH_WD-1:0] LAST_CH = CH_WD'(N_CH - 1);

   arb_state_t         r_state;
   logic [CH_WD-1:0]   r_ptr;
   logic [CH_WD-1:0]   r_lock_ch;
   logic               r_m_valid;
   logic               r_m_last;
   logic [DATA_WD-1:0] r_m_data;
   logic [CH_WD-1:0]   r_m_src;

   logic [CH_WD-1:0]   w_arb_grant;
   logic               w_arb_valid;
   logic [CH_WD-1:0]   w_grant;
   logic               w_grant_valid;
   logic               w_load_en;
   logic               w_xfer;
   logic               w_last;
   logic [DATA_WD-1:0] w_data;
   logic [N_CH-1:0]    w_s_ready;

   rr_arbiter #(
      .N_CH  (N_CH),
      .CH_WD (CH_WD)
   ) u_arb (
      .req         (bus.s_valid),
      .ptr         (r_ptr),
      .mode        (ARB_MODE == ARB_FIXED),
      .grant       (w_arb_grant),
      .grant_valid (w_arb_valid)
   );

   // A locked packet pins the grant; the arbiter result is ignored until its last beat.
   always_comb begin
      w_grant       = w_arb_grant;
      w_grant_valid = w_arb_valid;
      if (r_state == LOCKED) begin
         w_grant       = r_lock_ch;
         w_grant_valid = bus.s_valid[r_lock_ch];
      end
   end

   assign w_load_en = !r_m_valid || bus.m_ready;
   assign w_xfer    = w_load_en && w_grant_valid;
   assign w_last    = bus.s_last[w_grant];
   assign w_data    = bus.s_data[int'(w_grant)*DATA_WD +: DATA_WD];

   always_comb begin
      w_s_ready = '0;
      for (int i = 0; i < N_CH; i++) begin
         w_s_ready[i] = w_xfer && (w_grant == CH_WD'(i));
      end
   end

   // rstn gates the ready outputs so nothing is offered while reset is held.
   assign bus.s_ready = rstn ? w_s_ready : '0;
   assign bus.m_data  = r_m_data;
   assign bus.m_valid = r_m_valid;
   assign bus.m_last  = r_m_last;
   assign bus.m_src   = r_m_src;
   assign bus.busy    = (r_state == LOCKED);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state   <= IDLE;
         r_ptr     <= '0;
         r_lock_ch <= '0;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_m_last  <= 1'b0;
         r_m_src   <= '0;
      end else begin
         if (w_load_en) begin
            r_m_valid <= w_xfer;
            if (w_xfer) begin
               r_m_data <= w_data;
               r_m_last <= w_last;
               r_m_src  <= w_grant;
            end
         end
         if (w_xfer) begin
            case (r_state)
               IDLE: begin
                  if (!w_last) begin
                     r_state   <= LOCKED;
                     r_lock_ch <= w_grant;
                  end
               end
               LOCKED: begin
                  if (w_last) r_state <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
            if (w_last && (ARB_MODE == ARB_RR)) begin
               r_ptr <= (w_grant == LAST_CH) ? '0 : w_grant + 1'b1;
            end
         end
      end
   end

endmodule
